// File: rtl/pattern_search_pkg.sv
// Shared state encoding and counter-width helpers for the pattern_search sequencer.
package pattern_search_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_ARM    = 3'd2,
        ST_SEARCH = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // One spare bit so the write index can reach PATTERN_SIZE without wrapping.
    function automatic int idx_width(input int pattern_size);
        return $clog2(pattern_size) + 1;
    endfunction

    function automatic int cnt_width(input int info_size);
        return $clog2(info_size) + 1;
    endfunction

endpackage

// File: rtl/pattern_search_timeout.sv
// Idle-cycle counter between info bytes; used only when PATTERN_SEARCH_CTRL_TIMEOUT_EN is defined.
module pattern_search_timeout #(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] LAST_COUNT = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] count_reg;

    // Expires during the TIMEOUT_CYCLES-th consecutive idle cycle.
    assign expired = enable && (count_reg == LAST_COUNT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable) begin
            count_reg <= count_reg + 1'b1;
        end
    end

endmodule

// File: rtl/pattern_search_ctrl.sv
// Sequencer for pattern_search: loads the golden pattern, arms the searcher, gates characters, collects info bytes.
// Optional idle timeout between info bytes is enabled by defining PATTERN_SEARCH_CTRL_TIMEOUT_EN.
module pattern_search_ctrl
    import pattern_search_pkg::*;
#(
    parameter int N_BITS         = 8,
    parameter int PATTERN_SIZE   = 10,
    parameter int INFO_SIZE      = 2,
    parameter bit AUTO_REARM     = 1'b1,
    parameter bit GOLD_PRELOADED = 1'b0,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            load_start,
    input  logic [N_BITS-1:0]               cfg_byte,
    input  logic                            cfg_valid,
    output logic                            cfg_ready,
    input  logic                            search_en,
    input  logic                            abort,
    input  logic [N_BITS-1:0]               char_in,
    input  logic                            char_valid,
    output logic                            srch_rst,
    output logic [N_BITS-1:0]               char_out,
    output logic                            char_out_valid,
    output logic [N_BITS-1:0]               golden_word,
    output logic                            golden_word_valid,
    output logic [$clog2(PATTERN_SIZE)-1:0] golden_word_index,
    input  logic [N_BITS-1:0]               info_data,
    input  logic                            info_valid,
    output logic [INFO_SIZE*N_BITS-1:0]     result_data,
    output logic                            result_valid,
    input  logic                            result_ready,
    output logic                            pattern_loaded,
    output logic                            busy,
    output logic                            timeout_flag
);
    localparam int IDX_W      = idx_width(PATTERN_SIZE);
    localparam int CNT_W      = cnt_width(INFO_SIZE);
    localparam int PORT_IDX_W = $clog2(PATTERN_SIZE);
    localparam int RES_W      = INFO_SIZE * N_BITS;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PATTERN_SIZE - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(INFO_SIZE - 1);

    state_t                  state_reg;
    logic [IDX_W-1:0]        wr_idx_reg;
    logic [CNT_W-1:0]        info_cnt_reg;
    logic [RES_W-1:0]        result_reg;
    logic                    result_valid_reg;
    logic [N_BITS-1:0]       golden_word_reg;
    logic [PORT_IDX_W-1:0]   golden_idx_reg;
    logic                    golden_valid_reg;
    logic                    pattern_loaded_reg;
    logic                    timeout_flag_reg;
    logic                    timeout_expired;

    // Searcher is held in reset while idle and pulsed for the single ARM cycle.
    assign srch_rst          = (state_reg == ST_IDLE) || (state_reg == ST_ARM);
    assign cfg_ready         = (state_reg == ST_LOAD);
    assign busy              = (state_reg != ST_IDLE);
    assign char_out          = char_in;
    assign char_out_valid    = char_valid && (state_reg == ST_SEARCH);
    assign golden_word       = golden_word_reg;
    assign golden_word_valid = golden_valid_reg;
    assign golden_word_index = golden_idx_reg;
    assign result_data       = result_reg;
    assign result_valid      = result_valid_reg;
    assign pattern_loaded    = pattern_loaded_reg;
    assign timeout_flag      = timeout_flag_reg;

`ifdef PATTERN_SEARCH_CTRL_TIMEOUT_EN
    logic timeout_enable;
    logic timeout_clear;

    // Only count silence once a hit has started delivering info bytes.
    assign timeout_enable = (state_reg == ST_SEARCH) && (info_cnt_reg != '0) && !info_valid;
    assign timeout_clear  = (state_reg != ST_SEARCH) || info_valid;

    pattern_search_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clear  (timeout_clear),
        .enable (timeout_enable),
        .expired(timeout_expired)
    );
`else
    assign timeout_expired = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg          <= ST_IDLE;
            wr_idx_reg         <= '0;
            info_cnt_reg       <= '0;
            result_reg         <= '0;
            result_valid_reg   <= 1'b0;
            golden_word_reg    <= '0;
            golden_idx_reg     <= '0;
            golden_valid_reg   <= 1'b0;
            pattern_loaded_reg <= GOLD_PRELOADED;
            timeout_flag_reg   <= 1'b0;
        end else begin
            golden_valid_reg <= 1'b0;
            timeout_flag_reg <= 1'b0;
            if (abort && (state_reg != ST_IDLE)) begin
                state_reg        <= ST_IDLE;
                result_valid_reg <= 1'b0;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        if (load_start) begin
                            state_reg          <= ST_LOAD;
                            wr_idx_reg         <= '0;
                            pattern_loaded_reg <= 1'b0;
                        end else if (search_en && pattern_loaded_reg) begin
                            state_reg <= ST_ARM;
                        end
                    end
                    ST_LOAD: begin
                        if (cfg_valid) begin
                            golden_word_reg  <= cfg_byte;
                            golden_idx_reg   <= wr_idx_reg[PORT_IDX_W-1:0];
                            golden_valid_reg <= 1'b1;
                            wr_idx_reg       <= wr_idx_reg + 1'b1;
                            if (wr_idx_reg == LAST_IDX) begin
                                pattern_loaded_reg <= 1'b1;
                                state_reg          <= ST_ARM;
                            end
                        end
                    end
                    ST_ARM: begin
                        info_cnt_reg <= '0;
                        result_reg   <= '0;
                        state_reg    <= ST_SEARCH;
                    end
                    ST_SEARCH: begin
                        if (timeout_expired) begin
                            timeout_flag_reg <= 1'b1;
                            info_cnt_reg     <= '0;
                            result_reg       <= '0;
                            state_reg        <= ST_ARM;
                        end else if (info_valid) begin
                            // First byte received ends up in the MSBs.
                            result_reg   <= (result_reg << N_BITS) | RES_W'(info_data);
                            info_cnt_reg <= info_cnt_reg + 1'b1;
                            if (info_cnt_reg == LAST_CNT) begin
                                state_reg        <= ST_DONE;
                                result_valid_reg <= 1'b1;
                            end
                        end
                    end
                    ST_DONE: begin
                        if (result_ready && result_valid_reg) begin
                            result_valid_reg <= 1'b0;
                            state_reg        <= AUTO_REARM ? ST_ARM : ST_IDLE;
                        end
                    end
                    default: state_reg <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pattern_search_ctrl.sv
// Directed self-checking bench for pattern_search_ctrl (default parameters, TIMEOUT_CYCLES=50).
module tb_pattern_search_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_start = 1'b0;
    logic [7:0]  cfg_byte = '0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic        search_en = 1'b0;
    logic        abort = 1'b0;
    logic [7:0]  char_in = '0;
    logic        char_valid = 1'b0;
    logic        srch_rst;
    logic [7:0]  char_out;
    logic        char_out_valid;
    logic [7:0]  golden_word;
    logic        golden_word_valid;
    logic [3:0]  golden_word_index;
    logic [7:0]  info_data = '0;
    logic        info_valid = 1'b0;
    logic [15:0] result_data;
    logic        result_valid;
    logic        result_ready = 1'b0;
    logic        pattern_loaded;
    logic        busy;
    logic        timeout_flag;

    int checks = 0;
    int errors = 0;
    int gw_cnt = 0;

    always #5 clk = ~clk;

    pattern_search_ctrl #(
        .N_BITS(8), .PATTERN_SIZE(10), .INFO_SIZE(2), .AUTO_REARM(1'b1),
        .GOLD_PRELOADED(1'b0), .TIMEOUT_CYCLES(50)
    ) dut (
        .clk(clk), .rst(rst), .load_start(load_start), .cfg_byte(cfg_byte),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .search_en(search_en),
        .abort(abort), .char_in(char_in), .char_valid(char_valid),
        .srch_rst(srch_rst), .char_out(char_out), .char_out_valid(char_out_valid),
        .golden_word(golden_word), .golden_word_valid(golden_word_valid),
        .golden_word_index(golden_word_index), .info_data(info_data),
        .info_valid(info_valid), .result_data(result_data),
        .result_valid(result_valid), .result_ready(result_ready),
        .pattern_loaded(pattern_loaded), .busy(busy), .timeout_flag(timeout_flag)
    );

    // Count write strobes, one per cycle they are high.
    always @(negedge clk) if (golden_word_valid) gw_cnt++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-22s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    initial begin
        string pat;
        string stream;
        int    base;
        int    n;
        pat    = "HELLOWORLD";
        stream = "xxHELLOWORLD";

        // Reset state
        repeat (3) tick();
        chk("rst_busy", busy, 0);
        chk("rst_srch_rst", srch_rst, 1);
        chk("rst_result_valid", result_valid, 0);
        chk("rst_result_data", result_data, 0);
        chk("rst_pattern_loaded", pattern_loaded, 0);
        chk("rst_gw_valid", golden_word_valid, 0);
        chk("rst_gw_index", golden_word_index, 0);
        chk("rst_cfg_ready", cfg_ready, 0);
        chk("rst_timeout_flag", timeout_flag, 0);
        rst = 1'b0;
        tick();

        // search_en without a pattern is ignored
        search_en = 1'b1;
        tick();
        search_en = 1'b0;
        chk("idle_search_ignored", busy, 0);
        tick();
        chk("idle_still_idle", busy, 0);

        // Characters dropped in IDLE
        char_in = 8'h41; char_valid = 1'b1; #1;
        chk("idle_char_drop", char_out_valid, 0);
        char_valid = 1'b0;

        // load_start wins over search_en
        load_start = 1'b1; search_en = 1'b1;
        tick();
        load_start = 1'b0; search_en = 1'b0;
        chk("load_cfg_ready", cfg_ready, 1);
        chk("load_busy", busy, 1);
        chk("load_srch_rst", srch_rst, 0);
        char_valid = 1'b1; #1;
        chk("load_char_drop", char_out_valid, 0);
        char_valid = 1'b0;

        // Partial load of 4 bytes then abort
        base = gw_cnt;
        for (int i = 0; i < 4; i++) begin
            cfg_byte = pat[i]; cfg_valid = 1'b1;
            tick();
            cfg_valid = 1'b0;
            tick(); tick();
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_cfg_ready", cfg_ready, 0);
        chk("abort_pattern_loaded", pattern_loaded, 0);
        chk("abort_srch_rst", srch_rst, 1);
        cfg_byte = 8'h5A; cfg_valid = 1'b1;
        repeat (4) tick();
        cfg_valid = 1'b0;
        tick();
        chk("abort_strobe_count", gw_cnt - base, 4);

        // Full load of HELLOWORLD, one byte per 3 cycles
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        base = gw_cnt;
        for (int i = 0; i < 10; i++) begin
            cfg_byte = pat[i]; cfg_valid = 1'b1;
            tick();
            cfg_valid = 1'b0;
            chk($sformatf("gw_valid_%0d", i), golden_word_valid, 1);
            chk($sformatf("gw_data_%0d", i), golden_word, pat[i]);
            chk($sformatf("gw_index_%0d", i), golden_word_index, i);
            if (i == 8) chk("load_no_early_loaded", pattern_loaded, 0);
            if (i == 9) begin
                chk("load_done_loaded", pattern_loaded, 1);
                chk("arm_pulse_high", srch_rst, 1);
                chk("arm_cfg_ready", cfg_ready, 0);
            end
            tick();
            chk($sformatf("gw_valid_drop_%0d", i), golden_word_valid, 0);
            if (i == 9) chk("search_srch_rst_low", srch_rst, 0);
            tick();
        end
        chk("load_strobe_count", gw_cnt - base, 10);

        // SEARCH: characters pass through with zero latency
        for (int i = 0; i < stream.len(); i++) begin
            char_in = stream[i]; char_valid = 1'b1; #1;
            if (i == 0 || i == 5) begin
                chk($sformatf("pass_valid_%0d", i), char_out_valid, 1);
                chk($sformatf("pass_data_%0d", i), char_out, stream[i]);
            end
            tick();
        end
        char_valid = 1'b0; #1;
        chk("pass_valid_idle", char_out_valid, 0);

        // Info bytes 0x12 0x34 -> result 0x1234
        info_data = 8'h12; info_valid = 1'b1;
        tick();
        chk("info1_no_valid", result_valid, 0);
        info_data = 8'h34;
        tick();
        info_valid = 1'b0;
        chk("result_valid", result_valid, 1);
        chk("result_data", result_data, 16'h1234);
        char_valid = 1'b1; #1;
        chk("done_char_drop", char_out_valid, 0);
        char_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("hold_valid_%0d", i), result_valid, 1);
            chk($sformatf("hold_data_%0d", i), result_data, 16'h1234);
        end
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        chk("accept_valid_low", result_valid, 0);
        chk("rearm_srch_rst", srch_rst, 1);
        chk("rearm_busy", busy, 1);
        tick();
        chk("rearm_search", srch_rst, 0);
        char_in = 8'h77; char_valid = 1'b1; #1;
        chk("rearm_pass_valid", char_out_valid, 1);
        char_valid = 1'b0;

        // result_ready while no result has no effect
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        chk("stray_ready_busy", busy, 1);
        chk("stray_ready_srch_rst", srch_rst, 0);

        // Abort from SEARCH keeps the loaded pattern; search_en re-arms
        info_data = 8'hAB; info_valid = 1'b1;
        tick();
        info_valid = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_search_busy", busy, 0);
        chk("abort_search_loaded", pattern_loaded, 1);
        chk("abort_search_rvalid", result_valid, 0);
        search_en = 1'b1;
        tick();
        search_en = 1'b0;
        chk("search_en_arm", srch_rst, 1);
        chk("search_en_busy", busy, 1);
        tick();
        chk("search_en_search", srch_rst, 0);

        // Partial result must have been cleared by ARM
        info_data = 8'h56; info_valid = 1'b1;
        tick();
        info_data = 8'h78;
        tick();
        info_valid = 1'b0;
        chk("second_result", result_data, 16'h5678);
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        tick();

        // One info byte then silence
        info_data = 8'h99; info_valid = 1'b1;
        tick();
        info_valid = 1'b0;
`ifdef PATTERN_SEARCH_CTRL_TIMEOUT_EN
        n = 0;
        while (n < 200 && timeout_flag !== 1'b1) begin
            tick();
            n++;
        end
        chk("timeout_cycle", n, 50);
        chk("timeout_rearm", srch_rst, 1);
        chk("timeout_no_result", result_valid, 0);
        tick();
        chk("timeout_pulse_end", timeout_flag, 0);
        chk("timeout_search", srch_rst, 0);
`else
        n = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (timeout_flag) n++;
        end
        chk("no_timeout_flag", n, 0);
        chk("no_timeout_busy", busy, 1);
        chk("no_timeout_search", srch_rst, 0);
        chk("no_timeout_rvalid", result_valid, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
